// File: rtl/bitstream_shift_loader.sv
// -----------------------------------------------------------------------------
// bitstream_shift_loader
//
// Streams an eFPGA configuration bitstream from a byte-wide synchronous memory
// into the fabric's two-wire serial config port. Each 32-bit word is fetched
// as four bytes (byte 0 is the most significant), then shifted out MSB first.
// Every data bit is interleaved with one bit of a fixed control word. After
// the last word a user-design reset pulse is issued, followed by a done pulse.
//
// Ports:
//   CLK        in   system clock, all logic on the rising edge
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle load request, honoured only while idle
//   num_words  in   number of 32-bit words to send, sampled with start
//   rd_en      out  memory read strobe
//   rd_addr    out  memory byte address (0 whenever rd_en is low)
//   rd_data    in   memory read data, valid the cycle after rd_en
//   s_clk      out  serial config clock to the fabric
//   s_data     out  serial config data to the fabric
//   user_reset out  reset pulse to the configured user design
//   busy       out  high whenever the sequencer is not idle
//   done       out  one-cycle pulse at the end of a load
//
// Every output is a flop whose next value is decoded from the next-state
// values, so each output reflects the state the sequencer is in during that
// cycle and s_clk cannot glitch.
// -----------------------------------------------------------------------------
module bitstream_shift_loader #(
  parameter int unsigned ADDR_W          = 14,
  parameter logic [31:0] CTRL_WORD       = 32'h0000FAB1,
  parameter int unsigned USER_RST_CYCLES = 5
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-3:0] num_words,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              s_clk,
  output logic              s_data,
  output logic              user_reset,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned URST_W = (USER_RST_CYCLES > 1) ? $clog2(USER_RST_CYCLES) : 1;

  // State encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_URST  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Both FETCH and each SHIFT slot last five cycles (0..4)
  localparam logic [2:0]        LAST_CYC  = 3'd4;
  localparam logic [4:0]        LAST_SLOT = 5'd31;
  localparam logic [URST_W-1:0] LAST_URST = URST_W'(USER_RST_CYCLES - 1);

  // Sequencer state
  logic [2:0]        state_q,    state_d;
  logic [2:0]        cyc_q,      cyc_d;
  logic [4:0]        slot_q,     slot_d;
  logic [WORD_W-1:0] word_idx_q, word_idx_d;
  logic [WORD_W-1:0] num_q,      num_d;
  logic [31:0]       shreg_q,    shreg_d;
  logic [URST_W-1:0] urst_q,     urst_d;

  // Next output values
  logic              rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              s_clk_d;
  logic              s_data_d;
  logic              user_reset_d;
  logic              busy_d;
  logic              done_d;
  logic              shift_d;

  // State and output registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      slot_q     <= '0;
      word_idx_q <= '0;
      num_q      <= '0;
      shreg_q    <= '0;
      urst_q     <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      s_clk      <= 1'b0;
      s_data     <= 1'b0;
      user_reset <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      slot_q     <= slot_d;
      word_idx_q <= word_idx_d;
      num_q      <= num_d;
      shreg_q    <= shreg_d;
      urst_q     <= urst_d;
      rd_en      <= rd_en_d;
      rd_addr    <= rd_addr_d;
      s_clk      <= s_clk_d;
      s_data     <= s_data_d;
      user_reset <= user_reset_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    slot_d     = slot_q;
    word_idx_d = word_idx_q;
    num_d      = num_q;
    shreg_d    = shreg_q;
    urst_d     = urst_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d      = num_words;
          word_idx_d = '0;
          cyc_d      = '0;
          slot_d     = '0;
          shreg_d    = '0;
          urst_d     = '0;
          // An empty load skips straight to the user reset
          state_d    = (num_words == '0) ? ST_URST : ST_FETCH;
        end
      end

      ST_FETCH: begin
        // Reads go out in cycles 0..3; bytes land one cycle later (1..4)
        if (cyc_q != 3'd0) begin
          shreg_d = {shreg_q[23:0], rd_data};
        end
        if (cyc_q == LAST_CYC) begin
          state_d = ST_SHIFT;
          cyc_d   = '0;
          slot_d  = '0;
        end else begin
          cyc_d = cyc_q + 3'd1;
        end
      end

      ST_SHIFT: begin
        if (cyc_q == LAST_CYC) begin
          cyc_d = '0;
          if (slot_q == LAST_SLOT) begin
            slot_d = '0;
            // num_words is capped below 2^WORD_W, so the increment cannot wrap
            if ((word_idx_q + WORD_W'(1)) < num_q) begin
              word_idx_d = word_idx_q + WORD_W'(1);
              state_d    = ST_FETCH;
            end else begin
              urst_d  = '0;
              state_d = ST_URST;
            end
          end else begin
            slot_d = slot_q + 5'd1;
          end
        end else begin
          cyc_d = cyc_q + 3'd1;
        end
      end

      ST_URST: begin
        if (urst_q == LAST_URST) begin
          state_d = ST_DONE;
        end else begin
          urst_d = urst_q + URST_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs for the cycle the machine is about to enter
    rd_en_d      = (state_d == ST_FETCH) && (cyc_d != LAST_CYC);
    rd_addr_d    = rd_en_d ? {word_idx_d, cyc_d[1:0]} : '0;
    shift_d      = (state_d == ST_SHIFT);
    // Slot cycles 1-2 high: one rise (data sampled) and one fall (control sampled)
    s_clk_d      = shift_d && ((cyc_d == 3'd1) || (cyc_d == 3'd2));
    // ~slot_d selects bit 31-j; data leads for two cycles, control for three
    s_data_d     = shift_d && ((cyc_d < 3'd2) ? shreg_d[~slot_d] : CTRL_WORD[~slot_d]);
    user_reset_d = (state_d == ST_URST);
    done_d       = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_bitstream_shift_loader.sv
// -----------------------------------------------------------------------------
// tb_bitstream_shift_loader
//
// Self-checking bench for bitstream_shift_loader. A byte memory with one cycle
// of read latency feeds the DUT; a decoder samples s_data at every s_clk edge
// and the recovered words, edge timing, read addresses and pulse positions are
// compared with values computed from the memory contents and cycle arithmetic.
// A second instance built with USER_RST_CYCLES=1 checks the short-pulse case.
// -----------------------------------------------------------------------------
module tb_bitstream_shift_loader;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned NW     = ADDR_W - 2;
  localparam logic [31:0] CTRL   = 32'h0000FAB1;
  localparam int          URC    = 5;

  logic              CLK = 1'b0;
  logic              reset;
  logic              start, start1;
  logic [NW-1:0]     num_words, num_words1;
  logic              rd_en, rd_en1;
  logic [ADDR_W-1:0] rd_addr, rd_addr1;
  logic [7:0]        rd_data, rd_data1;
  logic              s_clk, s_clk1, s_data, s_data1;
  logic              user_reset, user_reset1, busy, busy1, done, done1;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  // Load observation record
  logic rise_bits[$];
  int   rise_idx[$];
  logic fall_bits[$];
  int   addrs[$];
  int   bcnt, urst_n, urst_first, done_n, done_idx;
  logic timed_out;

  always #5 CLK = ~CLK;

  // Synchronous memories, one cycle of read latency
  always @(posedge CLK) if (rd_en)  rd_data  <= mem[rd_addr];
  always @(posedge CLK) if (rd_en1) rd_data1 <= mem[rd_addr1];

  bitstream_shift_loader #(.ADDR_W(ADDR_W), .CTRL_WORD(CTRL), .USER_RST_CYCLES(URC)) u_dut (
    .CLK(CLK), .reset(reset), .start(start), .num_words(num_words),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .s_clk(s_clk), .s_data(s_data), .user_reset(user_reset), .busy(busy), .done(done)
  );

  bitstream_shift_loader #(.ADDR_W(ADDR_W), .CTRL_WORD(CTRL), .USER_RST_CYCLES(1)) u_dut1 (
    .CLK(CLK), .reset(reset), .start(start1), .num_words(num_words1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .s_clk(s_clk1), .s_data(s_data1), .user_reset(user_reset1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue a load on u_dut (caller is at a falling edge) and record everything
  // until busy drops. restart_at re-asserts start in that busy cycle.
  task automatic run_load(input int n, input int restart_at);
    logic prev;
    prev = 1'b0;
    rise_bits.delete(); rise_idx.delete(); fall_bits.delete(); addrs.delete();
    bcnt = 0; urst_n = 0; urst_first = -1; done_n = 0; done_idx = -1;
    timed_out = 1'b1;
    start = 1'b1;
    num_words = NW'(n);
    for (int c = 0; c < 20000; c++) begin
      @(negedge CLK);
      start = (c == restart_at);
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      if (s_clk && !prev) begin
        rise_bits.push_back(s_data);
        rise_idx.push_back(bcnt);
      end
      if (!s_clk && prev) fall_bits.push_back(s_data);
      if (rd_en) addrs.push_back(int'(rd_addr));
      if (user_reset) begin
        if (urst_n == 0) urst_first = bcnt;
        urst_n++;
      end
      if (done) begin
        done_n++;
        done_idx = bcnt;
      end
      prev = s_clk;
      bcnt++;
    end
    start = 1'b0;
  endtask

  // Compare the recorded load against the expected protocol for n words
  task automatic verify(input int n);
    logic [31:0] gw, fw, ew;
    int bad;
    check("timeout",      64'(timed_out), 64'(0));
    check("idle_outputs", 64'({rd_en, s_clk, s_data, user_reset, done}), 64'(0));
    check("busy_cycles",  64'(bcnt), 64'(165 * n + URC + 1));
    check("rise_count",   64'(rise_bits.size()), 64'(32 * n));
    check("fall_count",   64'(fall_bits.size()), 64'(32 * n));
    check("read_count",   64'(addrs.size()), 64'(4 * n));
    check("urst_len",     64'(urst_n), 64'(URC));
    check("urst_first",   64'(urst_first), 64'(165 * n));
    check("done_count",   64'(done_n), 64'(1));
    check("done_pos",     64'(done_idx), 64'(165 * n + URC));
    bad = 0;
    for (int i = 0; i < addrs.size(); i++) if (addrs[i] != i) bad++;
    check("addr_seq", 64'(bad), 64'(0));
    bad = 0;
    for (int k = 0; k < rise_idx.size(); k++)
      if (rise_idx[k] != 165 * (k / 32) + 5 * (k % 32) + 6) bad++;
    check("rise_timing", 64'(bad), 64'(0));
    if (rise_bits.size() == 32 * n && fall_bits.size() == 32 * n) begin
      for (int w = 0; w < n; w++) begin
        gw = '0; fw = '0;
        for (int j = 0; j < 32; j++) begin
          gw = {gw[30:0], rise_bits[32 * w + j]};
          fw = {fw[30:0], fall_bits[32 * w + j]};
        end
        ew = {mem[4 * w], mem[4 * w + 1], mem[4 * w + 2], mem[4 * w + 3]};
        check($sformatf("data_word%0d", w), 64'(gw), 64'(ew));
        check($sformatf("ctrl_word%0d", w), 64'(fw), 64'(CTRL));
      end
    end
  endtask

  initial begin
    logic prev;
    int   r, n;
    logic [31:0] gw;

    reset = 1'b1; start = 1'b0; start1 = 1'b0; num_words = '0; num_words1 = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'h3C;

    repeat (3) @(negedge CLK);
    check("reset_state", 64'({busy, rd_en, rd_addr, s_clk, s_data, user_reset, done}), 64'(0));
    reset = 1'b0;
    @(negedge CLK);

    // Single directed word
    run_load(1, -1);
    verify(1);
    gw = '0;
    if (rise_bits.size() >= 32)
      for (int j = 0; j < 32; j++) gw = {gw[30:0], rise_bits[j]};
    check("word_A500FF3C", 64'(gw), 64'(32'hA500FF3C));

    // Empty load
    run_load(0, -1);
    verify(0);

    // Three random words
    run_load(3, -1);
    verify(3);

    // start re-asserted during SHIFT of word 0 is ignored
    run_load(2, 40);
    verify(2);

    // Asynchronous reset at slot 17 of a single-word load
    start = 1'b1; num_words = NW'(1);
    prev = 1'b0; r = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      start = 1'b0;
      if (s_clk && !prev) r++;
      prev = s_clk;
      if (r == 18) break;
    end
    check("reached_slot17", 64'(r), 64'(18));
    reset = 1'b1;
    #1;
    check("async_reset", 64'({busy, rd_en, rd_addr, s_clk, s_data, user_reset, done}), 64'(0));
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    run_load(1, -1);
    verify(1);

    // Random word counts over fresh memory contents
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      n = int'($urandom_range(1, 4));
      run_load(n, -1);
      verify(n);
    end

    // USER_RST_CYCLES=1 instance
    start1 = 1'b1; num_words1 = NW'(1);
    prev = 1'b0; r = 0; bcnt = 0; urst_n = 0; urst_first = -1; done_n = 0; done_idx = -1;
    timed_out = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      start1 = 1'b0;
      if (!busy1) begin
        timed_out = 1'b0;
        break;
      end
      if (s_clk1 && !prev) r++;
      prev = s_clk1;
      if (user_reset1) begin
        if (urst_n == 0) urst_first = bcnt;
        urst_n++;
      end
      if (done1) begin
        done_n++;
        done_idx = bcnt;
      end
      bcnt++;
    end
    check("u1_timeout",    64'(timed_out), 64'(0));
    check("u1_busy",       64'(bcnt), 64'(167));
    check("u1_rises",      64'(r), 64'(32));
    check("u1_urst_len",   64'(urst_n), 64'(1));
    check("u1_urst_first", 64'(urst_first), 64'(165));
    check("u1_done_pos",   64'(done_idx), 64'(166));
    check("u1_done_count", 64'(done_n), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
